button_event_encoder: RTL and testbench
=======================================

// Module: button_event_encoder
// PURPOSE
//   Parametrised successor to the game's combinational button priority encoder.
//   Synchronises and debounces N_CH raw push-buttons, then turns presses into a priority-encoded event stream.
//   Events use a valid/ready handshake and support optional auto-repeat on held channels.
//   Sits between the board buttons and the game-control FSM, which consumes one event per handshake.
// PARAMETERS
//   N_CH         7          number of button channels; bit N_CH-1 = highest priority
//   CODE_W       3          event code width; must satisfy 2**CODE_W > N_CH (elaboration error otherwise)
//   DB_CYCLES    20         consecutive stable cycles required to accept a level change (>=1)
//   REPEAT_DELAY 500        cycles from press event to first repeat event
//   REPEAT_RATE  100        cycles between subsequent repeat events (>=1)
//   REPEAT_MASK  7'b0001111 per-channel auto-repeat enable (1 = repeats while held)
// PORTS
//   clk       in   1       system clock
//   rst       in   1       asynchronous, active-high reset
//   btn_in    in   N_CH    raw button levels, asynchronous to clk, 1 = pressed
//   ev_valid  out  1       event available
//   ev_ready  in   1       consumer accepts event when ev_valid & ev_ready
//   ev_code   out  CODE_W  channel index of event; all-ones = idle/no event
//   ev_repeat out  1       1 = event is an auto-repeat, 0 = fresh press
//   ev_drop   out  1       one-cycle pulse: an event was discarded (output busy)
//   held_code out  CODE_W  index of highest-priority debounced-held channel; all-ones if none
// BEHAVIOUR
//   Reset (async, rst=1)
//   - sync/stable vectors = 0, debounce and repeat counters = 0, FSM = IDLE.
//   - ev_valid=0, ev_code=all-ones, ev_repeat=0, ev_drop=0, held_code=all-ones.
//   Sync/debounce
//   - Per channel: 2-FF synchroniser, then a counter.
//   - Counter increments while the sync level != stable level and clears when they agree.
//   - At DB_CYCLES the stable level flips and the counter clears, so glitches shorter than DB_CYCLES are ignored.
//   Press detection
//   - rise = stable & ~stable_d.
//   - If several channels rise in the same cycle, the highest index wins; the others are discarded silently (not queued, no ev_drop).
//   Latency
//   - First clk edge sampling a new btn_in level = edge 0; ev_valid rises at edge DB_CYCLES+2.
//   - Synchroniser uncertainty adds +1.
//   Output register (1 entry)
//   - Loads {code, repeat} when an event is generated and (ev_valid==0 or ev_ready==1).
//   - Accept and new event in the same cycle: load the new event, ev_valid stays 1.
//   - New event while ev_valid & ~ev_ready: event discarded, ev_drop=1 for that cycle, held event unchanged.
//   - ev_code and ev_repeat are stable while ev_valid=1 and not accepted.
//   Repeat FSM (tracks held_code)
//   - IDLE: press event for a channel with REPEAT_MASK=1 -> DELAY, counter=0.
//   - DELAY: after REPEAT_DELAY cycles, emit repeat (ev_repeat=1, code=held_code) -> RPT, counter=0.
//   - RPT: emit a repeat every REPEAT_RATE cycles.
//   - DELAY/RPT on held_code change:
//     - all released -> IDLE;
//     - held_code changes to a masked channel -> DELAY, counter=0;
//     - held_code changes to an unmasked channel -> IDLE.
//   - Repeats are subject to the same drop rule as presses.
//   - Releases never generate events.
//   - Buttons held through reset deassertion generate a normal press event DB_CYCLES+2 edges later.
//   - Reset mid-debounce or mid-repeat aborts immediately; no event is emitted.
// TESTING (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5, N_CH=7, CODE_W=3)
//   1. btn_in[2]=1 held, ev_ready=1
//      -> ev_valid pulse at edge 6 with ev_code=2, ev_repeat=0; held_code=2.
//   2. btn_in[4] glitch high for 3 cycles
//      -> no event, held_code stays 7.
//   3. btn_in[6] and btn_in[1] rise in the same cycle
//      -> single event code=6; ev_drop stays 0.
//   4. ev_ready=0, press ch0, then ch3 after 20 cycles
//      -> ev_code stays 0, ev_drop pulses once; set ev_ready=1 -> handshake completes.
//   5. Hold ch1 (masked) with ev_ready=1
//      -> press at edge 6, repeats (ev_repeat=1, code=1) at 16, 21, 26; release -> no further events.
//   6. Hold ch5 (unmasked) 100 cycles -> exactly one event; assert rst mid-hold
//      -> ev_valid=0, ev_code=7 immediately (async).

Source files
------------

// File: rtl/button_event_encoder.sv
// Debounced, priority-encoded push-button event source with a one-entry valid/ready
// output register and optional per-channel auto-repeat while a button stays held.
module button_event_encoder #(
    parameter int              N_CH         = 7,
    parameter int              CODE_W       = 3,
    parameter int              DB_CYCLES    = 20,
    parameter int              REPEAT_DELAY = 500,
    parameter int              REPEAT_RATE  = 100,
    parameter logic [N_CH-1:0] REPEAT_MASK  = 7'b0001111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   btn_in,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CODE_W-1:0] ev_code,
    output logic              ev_repeat,
    output logic              ev_drop,
    output logic [CODE_W-1:0] held_code
);

    localparam logic [CODE_W-1:0] IDLE_CODE = '1;
    localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [RC_W-1:0] DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0] RATE_LAST  = RC_W'(REPEAT_RATE - 1);

    generate
        if ((1 << CODE_W) <= N_CH) begin : g_code_w_check
            $error("CODE_W too narrow: 2**CODE_W must exceed N_CH");
        end
    endgenerate

    function automatic logic [CODE_W-1:0] prio_enc(input logic [N_CH-1:0] v);
        logic [CODE_W-1:0] code;
        code = IDLE_CODE;
        for (int k = 0; k < N_CH; k++) begin
            if (v[k]) code = CODE_W'(k);
        end
        return code;
    endfunction

    function automatic logic is_masked(input logic [CODE_W-1:0] code);
        logic m;
        m = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (code == CODE_W'(k)) m = REPEAT_MASK[k];
        end
        return m;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RPT} rpt_state_t;

    logic [N_CH-1:0]   r_sync1, r_sync2, r_stable, r_stable_d;
    logic [DB_W-1:0]   r_db_cnt [N_CH];
    rpt_state_t        r_state;
    logic [RC_W-1:0]   r_rcnt;
    logic              r_ev_valid, r_ev_repeat, r_ev_drop;
    logic [CODE_W-1:0] r_ev_code;

    logic [N_CH-1:0]   w_rise;
    logic              w_press, w_held_chg, w_rpt_fire, w_ev_gen;
    logic [CODE_W-1:0] w_press_code, w_held, w_held_prev, w_ev_code;

    // Stage 1: synchronise and debounce every channel independently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable   <= '0;
            r_stable_d <= '0;
            for (int k = 0; k < N_CH; k++) r_db_cnt[k] <= '0;
        end else begin
            r_sync1    <= btn_in;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int k = 0; k < N_CH; k++) begin
                if (r_sync2[k] == r_stable[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_LAST) begin
                    r_stable[k] <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    assign w_rise       = r_stable & ~r_stable_d;
    assign w_press      = |w_rise;
    assign w_press_code = prio_enc(w_rise);
    assign w_held       = prio_enc(r_stable);
    assign w_held_prev  = prio_enc(r_stable_d);
    assign w_held_chg   = (w_held != w_held_prev);
    assign held_code    = w_held;

    // A held_code change restarts or cancels the repeat timer instead of firing
    assign w_rpt_fire = !w_held_chg &&
                        (((r_state == S_DELAY) && (r_rcnt == DELAY_LAST)) ||
                         ((r_state == S_RPT)   && (r_rcnt == RATE_LAST)));

    // Stage 2: auto-repeat timer following the highest held channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_press && is_masked(w_press_code)) begin
                        r_state <= S_DELAY;
                        r_rcnt  <= '0;
                    end
                end
                default: begin
                    if (w_held_chg) begin
                        r_state <= is_masked(w_held) ? S_DELAY : S_IDLE;
                        r_rcnt  <= '0;
                    end else if (w_rpt_fire) begin
                        r_state <= S_RPT;
                        r_rcnt  <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + RC_W'(1);
                    end
                end
            endcase
        end
    end

    // A fresh press outranks a repeat falling due in the same cycle
    assign w_ev_gen  = w_press | w_rpt_fire;
    assign w_ev_code = w_press ? w_press_code : w_held;

    // Stage 3: one-entry output register with drop-on-busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ev_valid  <= 1'b0;
            r_ev_code   <= IDLE_CODE;
            r_ev_repeat <= 1'b0;
            r_ev_drop   <= 1'b0;
        end else begin
            r_ev_drop <= w_ev_gen & r_ev_valid & ~ev_ready;
            if (w_ev_gen && (!r_ev_valid || ev_ready)) begin
                r_ev_valid  <= 1'b1;
                r_ev_code   <= w_ev_code;
                r_ev_repeat <= ~w_press;
            end else if (r_ev_valid && ev_ready) begin
                r_ev_valid  <= 1'b0;
                r_ev_code   <= IDLE_CODE;
                r_ev_repeat <= 1'b0;
            end
        end
    end

    assign ev_valid  = r_ev_valid;
    assign ev_code   = r_ev_code;
    assign ev_repeat = r_ev_repeat;
    assign ev_drop   = r_ev_drop;

endmodule

// File: tb/tb_button_event_encoder.sv
// Bench for button_event_encoder: directed scenarios with literal expectations plus
// randomised buttons/ready/reset compared every cycle against a cycle-level event model.
module tb_button_event_encoder;

    localparam int N    = 7;
    localparam int DB   = 4;
    localparam int DLY  = 10;
    localparam int RATE = 5;
    localparam logic [6:0] MASK = 7'b0001111;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [6:0] btn_in   = '0;
    logic       ev_ready = 1'b1;
    logic       ev_valid, ev_repeat, ev_drop;
    logic [2:0] ev_code, held_code;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    button_event_encoder #(
        .N_CH(N), .CODE_W(3), .DB_CYCLES(DB), .REPEAT_DELAY(DLY),
        .REPEAT_RATE(RATE), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_repeat(ev_repeat), .ev_drop(ev_drop), .held_code(held_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] m_s1, m_s2, m_stab, m_prev;
    int         m_run [N];
    int         m_cyc = 0;
    bit         m_active;
    int         m_due;
    bit         m_valid, m_rep, m_drop;
    int         m_code;

    function automatic int top(input logic [6:0] v);
        for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
        return 7;
    endfunction

    function automatic bit masked(input int h);
        if (h < 0 || h >= N) return 1'b0;
        return MASK[h];
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stab = '0; m_prev = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_active = 1'b0; m_due = 0;
        m_valid = 1'b0; m_code = 7; m_rep = 1'b0; m_drop = 1'b0;
    endtask

    task automatic model_step();
        int pc, h, hp;
        bit press, fire, gen;
        logic [6:0] nstab;
        pc    = top(m_stab & ~m_prev);
        press = (pc != 7);
        h     = top(m_stab);
        hp    = top(m_prev);
        fire  = 1'b0;
        if (m_active) begin
            if (h != hp) begin
                if (masked(h)) m_due = m_cyc + DLY;
                else           m_active = 1'b0;
            end else if (m_cyc == m_due) begin
                fire  = 1'b1;
                m_due = m_cyc + RATE;
            end
        end else if (press && masked(pc)) begin
            m_active = 1'b1;
            m_due    = m_cyc + DLY;
        end
        gen    = press || fire;
        m_drop = gen && m_valid && !ev_ready;
        if (gen && (!m_valid || ev_ready)) begin
            m_valid = 1'b1;
            m_code  = press ? pc : h;
            m_rep   = !press;
        end else if (m_valid && ev_ready) begin
            m_valid = 1'b0; m_code = 7; m_rep = 1'b0;
        end
        nstab = m_stab;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    nstab[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_prev = m_stab;
        m_stab = nstab;
        m_s2   = m_s1;
        m_s1   = btn_in;
        m_cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_valid",  ev_valid,  m_valid);
                check("cyc_code",   ev_code,   m_code);
                check("cyc_repeat", ev_repeat, m_rep);
                check("cyc_drop",   ev_drop,   m_drop);
                check("cyc_held",   held_code, top(m_stab));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int idx;
        int glen;
        tick(3);
        check("rst_valid",  ev_valid,  0);
        check("rst_code",   ev_code,   7);
        check("rst_repeat", ev_repeat, 0);
        check("rst_drop",   ev_drop,   0);
        check("rst_held",   held_code, 7);
        cmp_en = 1'b1;
        rst = 1'b0;
        tick(2);

        // single press of ch2
        btn_in[2] = 1'b1;
        tick(6);
        check("t1_edge5_valid", ev_valid, 0);
        tick(1);
        check("t1_valid",  ev_valid,  1);
        check("t1_code",   ev_code,   2);
        check("t1_repeat", ev_repeat, 0);
        check("t1_held",   held_code, 2);
        tick(1);
        check("t1_accepted", ev_valid, 0);
        btn_in[2] = 1'b0;
        tick(20);

        // short glitch is filtered
        btn_in[4] = 1'b1;
        tick(3);
        btn_in[4] = 1'b0;
        tick(12);
        check("t2_held",  held_code, 7);
        check("t2_valid", ev_valid,  0);

        // simultaneous rise, highest index wins
        btn_in = 7'b1000010;
        tick(7);
        check("t3_valid", ev_valid, 1);
        check("t3_code",  ev_code,  6);
        check("t3_drop",  ev_drop,  0);
        tick(1);
        check("t3_drop_next", ev_drop,  0);
        check("t3_no_second", ev_valid, 0);
        btn_in = '0;
        tick(20);

        // busy output: second press is dropped
        ev_ready = 1'b0;
        btn_in[0] = 1'b1;
        tick(7);
        check("t4_valid0", ev_valid, 1);
        check("t4_code0",  ev_code,  0);
        tick(1);
        btn_in[0] = 1'b0;
        tick(12);
        btn_in[3] = 1'b1;
        tick(7);
        check("t4_drop",      ev_drop,  1);
        check("t4_code_kept", ev_code,  0);
        check("t4_valid_kept", ev_valid, 1);
        tick(1);
        check("t4_drop_end",  ev_drop,  0);
        check("t4_code_hold", ev_code,  0);
        btn_in[3] = 1'b0;
        ev_ready  = 1'b1;
        tick(1);
        check("t4_handshake", ev_valid, 0);
        tick(20);

        // auto-repeat on masked ch1
        btn_in[1] = 1'b1;
        tick(7);
        check("t5_press_valid", ev_valid,  1);
        check("t5_press_code",  ev_code,   1);
        check("t5_press_rep",   ev_repeat, 0);
        tick(9);
        check("t5_e15_valid", ev_valid, 0);
        tick(1);
        check("t5_r16_valid", ev_valid, 1);
        check("t5_r16_code",  ev_code,  1);
        check("t5_r16_rep",   ev_repeat, 1);
        tick(5);
        check("t5_r21_valid", ev_valid, 1);
        check("t5_r21_rep",   ev_repeat, 1);
        tick(5);
        check("t5_r26_valid", ev_valid, 1);
        check("t5_r26_rep",   ev_repeat, 1);
        btn_in[1] = 1'b0;
        tick(30);

        // unmasked hold: single event, then async reset
        btn_in[5] = 1'b1;
        n = 0;
        repeat (100) begin
            tick(1);
            if (ev_valid === 1'b1) n++;
        end
        check("t6_events", n, 1);
        ev_ready  = 1'b0;
        btn_in[6] = 1'b1;
        tick(7);
        check("t6_pre_rst_valid", ev_valid, 1);
        check("t6_pre_rst_code",  ev_code,  6);
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", ev_valid,  0);
        check("t6_async_code",  ev_code,   7);
        check("t6_async_held",  held_code, 7);
        tick(2);
        rst = 1'b0;
        tick(7);
        check("t6_held_thru_rst_valid", ev_valid, 1);
        check("t6_held_thru_rst_code",  ev_code,  6);
        ev_ready = 1'b1;
        btn_in   = '0;
        tick(20);

        // randomised buttons, ready and occasional reset
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) begin
                idx = $urandom_range(0, N - 1);
                btn_in[idx] = ~btn_in[idx];
            end
            ev_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                idx  = $urandom_range(0, N - 1);
                glen = $urandom_range(1, 3);
                btn_in[idx] = ~btn_in[idx];
                tick(glen);
                btn_in[idx] = ~btn_in[idx];
            end
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                tick(1 + $urandom_range(0, 1));
                rst = 1'b0;
            end
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
